// File: rtl/wb_pkg.sv
// Shared types and bus widths for the Wishbone burst master.
package wb_pkg;

    localparam int WB_AW   = 30;
    localparam int WB_DW   = 32;
    localparam int WB_SELW = 4;

    // Beat counters hold 0..16, so they need one bit more than the length field.
    localparam int BEAT_W  = 5;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    // A length field of zero stands for a full 16-beat burst.
    function automatic logic [BEAT_W-1:0] decode_len(input logic [3:0] len);
        return (len == 4'd0) ? BEAT_W'(16) : {1'b0, len};
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// No-progress watchdog: counts cycles while running, restarts on clear, and
// flags the cycle whose count would reach LIMIT.
module wb_watchdog #(
    parameter int WIDTH = 10,
    parameter int LIMIT = 1023
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    logic [WIDTH-1:0] count;

    // Expire on the edge that would take the count to LIMIT so the abort
    // lands exactly LIMIT cycles after the last progress event.
    assign expired = run && !clear && (count == WIDTH'(LIMIT - 1));

    // Restart on progress, otherwise count idle cycles while the bus is held.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone pipelined burst master: accepts one command, issues up to 16
// incrementing beats, waits for all acks, then reports done/err.
module wb_burst_master
    import wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic               i_cmd_we,
    input  logic [WB_AW-1:0]   i_cmd_addr,
    input  logic [3:0]         i_cmd_len,
    input  logic [WB_SELW-1:0] i_cmd_sel,
    input  logic [WB_DW-1:0]   i_wr_data,
    output logic               o_wr_pop,
    output logic               o_rd_valid,
    output logic [WB_DW-1:0]   o_rd_data,
    output logic               o_done,
    output logic               o_err,
    output logic               o_wb_cyc,
    output logic               o_wb_stb,
    output logic               o_wb_we,
    output logic [WB_AW-1:0]   o_wb_addr,
    output logic [WB_DW-1:0]   o_wb_data,
    output logic [WB_SELW-1:0] o_wb_sel,
    input  logic               i_wb_ack,
    input  logic               i_wb_stall,
    input  logic               i_wb_err,
    input  logic [WB_DW-1:0]   i_wb_data
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t            state;
    logic [BEAT_W-1:0] beats_left;
    logic [BEAT_W-1:0] outstanding;
    logic              accept;
    logic              issue;
    logic              ack;
    logic              bus_err;
    logic              wd_expired;
    logic              abort;

    // Slave responses only matter while the cycle is open.
    assign o_cmd_ready = (state == IDLE) && !i_reset;
    assign accept      = i_cmd_valid && o_cmd_ready;
    assign issue       = o_wb_stb && !i_wb_stall;
    assign ack         = o_wb_cyc && i_wb_ack;
    assign bus_err     = o_wb_cyc && i_wb_err;
    assign abort       = bus_err || wd_expired;

    wb_watchdog #(
        .WIDTH (WD_W),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .clear   (accept || issue || ack),
        .run     (o_wb_cyc),
        .expired (wd_expired)
    );

    // Read return path: one-cycle registered copy of ack/data; an ack that
    // coincides with an error is dropped along with the burst.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_rd_valid <= 1'b0;
            o_rd_data  <= '0;
        end else begin
            o_rd_valid <= ack && !o_wb_we && !i_wb_err;
            if (ack && !o_wb_we && !i_wb_err) begin
                o_rd_data <= i_wb_data;
            end
        end
    end

    // Burst sequencer: command latch, beat issue, ack drain and abort.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= IDLE;
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_wb_we     <= 1'b0;
            o_wb_addr   <= '0;
            o_wb_data   <= '0;
            o_wb_sel    <= '0;
            beats_left  <= '0;
            outstanding <= '0;
            o_wr_pop    <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_wr_pop <= 1'b0;
            o_done   <= 1'b0;
            o_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        o_wb_we     <= i_cmd_we;
                        o_wb_addr   <= i_cmd_addr;
                        o_wb_sel    <= i_cmd_sel;
                        o_wb_data   <= i_wr_data;
                        beats_left  <= decode_len(i_cmd_len);
                        outstanding <= '0;
                        o_wb_cyc    <= 1'b1;
                        o_wb_stb    <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE, DRAIN: begin
                    if (abort) begin
                        o_wb_cyc    <= 1'b0;
                        o_wb_stb    <= 1'b0;
                        outstanding <= '0;
                        beats_left  <= '0;
                        o_done      <= 1'b1;
                        o_err       <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        outstanding <= outstanding + BEAT_W'(issue) - BEAT_W'(ack);
                        if (issue) begin
                            o_wb_addr  <= o_wb_addr + WB_AW'(1);
                            beats_left <= beats_left - BEAT_W'(1);
                            if (o_wb_we) begin
                                o_wb_data <= i_wr_data;
                                o_wr_pop  <= 1'b1;
                            end
                            if (beats_left == BEAT_W'(1)) begin
                                o_wb_stb <= 1'b0;
                                state    <= DRAIN;
                            end
                        end
                        if (state == DRAIN && outstanding == '0) begin
                            o_wb_cyc <= 1'b0;
                            o_done   <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
